multi_rate_counter: RTL and testbench

MULTI_RATE_COUNTER -- requirements
Module: multi_rate_counter

---
 rtl/multi_rate_counter.sv | 92 +++++++++
 tb/tb_multi_rate_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_counter.sv
// multi_rate_counter: per-channel programmable tick dividers driving key-controlled up/down counters.
module multi_rate_counter #(
    parameter int n_ch        = 2,
    parameter int w_cnt       = 16,
    parameter int min_period  = 540000,
    parameter int max_period  = 81000000,
    parameter int period_step = 1,
    parameter int w_key       = 8,
    parameter int w_led       = 8,
    parameter int w_digit     = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [w_key-1:0]                           key,
    output logic [w_led-1:0]                           led,
    output logic [w_digit*4-1:0]                       number,
    output logic [n_ch-1:0]                            tick,
    output logic [n_ch-1:0]                            run,
    output logic [n_ch-1:0]                            dir,
    output logic [(n_ch > 1 ? $clog2(n_ch) : 1)-1:0]   sel
);
    localparam int w_sel = n_ch > 1 ? $clog2(n_ch) : 1;
    localparam int w_num = w_digit * 4;
    localparam int w_per = $clog2(max_period + period_step + 1);
    localparam logic [w_per-1:0] p_min  = w_per'(min_period);
    localparam logic [w_per-1:0] p_max  = w_per'(max_period);
    localparam logic [w_per-1:0] p_step = w_per'(period_step);
    localparam logic [w_per-1:0] p_init = w_per'((min_period + max_period) / 2);

    logic [w_per-1:0] period [n_ch];
    logic [w_per-1:0] period_n [n_ch];
    logic [w_per-1:0] div [n_ch];
    logic [w_per-1:0] div_n [n_ch];
    logic [w_cnt-1:0] count [n_ch];
    logic [w_cnt-1:0] count_n [n_ch];
    logic [n_ch-1:0]  tick_n, run_n, dir_n, hit, clr;
    logic [w_sel-1:0] sel_n;
    logic [w_key-1:0] key_prev;
    logic [5:2]       rise;
    logic [w_cnt-1:0] shown;
    logic             unused_key;

    assign rise       = key[5:2] & ~key_prev[5:2];
    assign sel_n      = rise[4] ? (sel == w_sel'(n_ch - 1) ? '0 : sel + w_sel'(1)) : sel;
    assign shown      = count_n[sel_n];
    assign unused_key = ^{key, key_prev};

    // key actions use the current sel; the period register only feeds div at a reload
    always_comb begin
        for (int i = 0; i < n_ch; i++) begin
            hit[i]      = w_sel'(i) == sel;
            clr[i]      = hit[i] && rise[5];
            period_n[i] = !hit[i] ? period[i]
                        : key[0] ? (period[i] > p_max - p_step ? p_max : period[i] + p_step)
                        : key[1] ? (period[i] < p_min + p_step ? p_min : period[i] - p_step)
                        : period[i];
            tick_n[i]   = run[i] && div[i] == '0 && !clr[i];
            div_n[i]    = clr[i] || tick_n[i] ? period[i] - w_per'(1)
                        : run[i] ? div[i] - w_per'(1) : div[i];
            count_n[i]  = clr[i] ? '0 : !tick_n[i] ? count[i]
                        : dir[i] ? count[i] - w_cnt'(1) : count[i] + w_cnt'(1);
            run_n[i]    = run[i] ^ (hit[i] && rise[2]);
            dir_n[i]    = dir[i] ^ (hit[i] && rise[3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period   <= '{default: p_init};
            div      <= '{default: '0};
            count    <= '{default: '0};
            tick     <= '0;
            run      <= '1;
            dir      <= '0;
            sel      <= '0;
            key_prev <= '0;
            led      <= '0;
            number   <= '0;
        end else begin
            period   <= period_n;
            div      <= div_n;
            count    <= count_n;
            tick     <= tick_n;
            run      <= run_n;
            dir      <= dir_n;
            sel      <= sel_n;
            key_prev <= key;
            led      <= w_led'(shown);
            number   <= w_num'(shown);
        end
    end
endmodule

// File: tb/tb_multi_rate_counter.sv
// tb_multi_rate_counter: directed key sequences checked against a behavioural channel model.
module tb_multi_rate_counter;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key;
    logic [7:0]  led;
    logic [31:0] number;
    logic [1:0]  tick, run, dir;
    logic [0:0]  sel;

    int vec = 0;
    int errs = 0;
    bit armed = 0;

    int   m_per [2];
    int   m_left [2];
    int   m_cnt [2];
    bit   m_run [2];
    bit   m_dir [2];
    bit   m_tick [2];
    int   m_sel;
    logic [7:0] m_prev;

    multi_rate_counter #(
        .n_ch(2), .w_cnt(4), .min_period(4), .max_period(12), .period_step(3),
        .w_key(8), .w_led(8), .w_digit(8)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .led(led), .number(number),
        .tick(tick), .run(run), .dir(dir), .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each channel counts down the cycles left before its next tick.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_per[i]  <= 8;
                m_left[i] <= 0;
                m_cnt[i]  <= 0;
                m_run[i]  <= 1;
                m_dir[i]  <= 0;
                m_tick[i] <= 0;
            end
            m_sel  <= 0;
            m_prev <= '0;
        end else begin
            m_prev <= key;
            if (key[4] && !m_prev[4]) m_sel <= (m_sel + 1) % 2;
            for (int i = 0; i < 2; i++) begin
                if (i == m_sel && key[0]) m_per[i] <= (m_per[i] + 3 > 12) ? 12 : m_per[i] + 3;
                else if (i == m_sel && key[1]) m_per[i] <= (m_per[i] - 3 < 4) ? 4 : m_per[i] - 3;
                if (i == m_sel && key[2] && !m_prev[2]) m_run[i] <= !m_run[i];
                if (i == m_sel && key[3] && !m_prev[3]) m_dir[i] <= !m_dir[i];
                if (i == m_sel && key[5] && !m_prev[5]) begin
                    m_cnt[i]  <= 0;
                    m_left[i] <= m_per[i] - 1;
                    m_tick[i] <= 0;
                end else if (!m_run[i]) begin
                    m_tick[i] <= 0;
                end else if (m_left[i] == 0) begin
                    m_tick[i] <= 1;
                    m_left[i] <= m_per[i] - 1;
                    m_cnt[i]  <= (m_cnt[i] + (m_dir[i] ? 15 : 1)) % 16;
                end else begin
                    m_tick[i] <= 0;
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("tick", int'(tick), int'({m_tick[1], m_tick[0]}));
            chk("run", int'(run), int'({m_run[1], m_run[0]}));
            chk("dir", int'(dir), int'({m_dir[1], m_dir[0]}));
            chk("sel", int'(sel), m_sel);
            chk("led", int'(led), m_cnt[m_sel]);
            chk("number", int'(number), m_cnt[m_sel]);
        end
    end

    task automatic cyc(input logic [7:0] k, input int n);
        key = k;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        key = '0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1;
        chk("reset_led", int'(led), 0);
        chk("reset_run", int'(run), 3);
        @(negedge clk);
        rst = 1'b0;
        // first tick on edge 1, then every 8 cycles
        cyc(8'h00, 1);
        chk("e1_tick", int'(tick), 3);
        chk("e1_led", int'(led), 1);
        cyc(8'h00, 7);
        chk("e8_tick", int'(tick), 0);
        cyc(8'h00, 1);
        chk("e9_led", int'(led), 2);
        cyc(8'h00, 8);
        chk("e17_tick", int'(tick), 3);
        chk("e17_led", int'(led), 3);
        chk("e17_number", int'(number), 3);
        // period 8 -> 12 -> 4; in-flight div keeps its tick at edge 25
        cyc(8'h01, 4);
        cyc(8'h02, 4);
        chk("e25_tick", int'(tick), 3);
        chk("e25_led", int'(led), 4);
        cyc(8'h00, 4);
        chk("e29_tick", int'(tick), 1);
        chk("e29_led", int'(led), 5);
        // clear coinciding with a ch0 tick at edge 33
        cyc(8'h00, 3);
        cyc(8'h20, 1);
        chk("clr_tick", int'(tick), 2);
        chk("clr_led", int'(led), 0);
        // count down from 0 wraps to 15, then back up to 0
        cyc(8'h08, 1);
        cyc(8'h00, 3);
        chk("wrap_down_led", int'(led), 15);
        chk("wrap_down_dir", int'(dir), 1);
        cyc(8'h08, 1);
        cyc(8'h00, 3);
        chk("wrap_up_led", int'(led), 0);
        chk("wrap_up_tick", int'(tick), 3);
        // period 4 -> 7, pause with div frozen at 5, resume ticks 6 cycles later
        cyc(8'h01, 1);
        cyc(8'h00, 3);
        chk("e45_tick", int'(tick), 1);
        cyc(8'h04, 1);
        cyc(8'h00, 20);
        chk("pause_run", int'(run), 2);
        chk("pause_led", int'(led), 1);
        cyc(8'h04, 1);
        cyc(8'h00, 5);
        chk("resume_early", int'(tick[0]), 0);
        cyc(8'h00, 1);
        chk("resume_tick", int'(tick[0]), 1);
        chk("resume_led", int'(led), 2);
        // select channel 1 and lengthen only its period
        cyc(8'h10, 1);
        chk("sel1", int'(sel), 1);
        chk("sel1_led", int'(led), 10);
        cyc(8'h01, 1);
        cyc(8'h00, 6);
        chk("e81_tick", int'(tick), 2);
        chk("e81_led", int'(led), 11);
        cyc(8'h00, 11);
        chk("e92_tick", int'(tick), 2);
        chk("e92_led", int'(led), 12);
        // run toggle and sel advance together act on the old sel
        cyc(8'h14, 1);
        chk("combo_run", int'(run), 1);
        chk("combo_sel", int'(sel), 0);
        chk("combo_led", int'(led), 4);
        cyc(8'h00, 10);
        // asynchronous reset mid-count with a key held across release
        key = 8'h10;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_tick", int'(tick), 0);
        chk("arst_led", int'(led), 0);
        chk("arst_number", int'(number), 0);
        chk("arst_run", int'(run), 3);
        chk("arst_dir", int'(dir), 0);
        chk("arst_sel", int'(sel), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h10, 1);
        chk("held_key_sel", int'(sel), 1);
        chk("held_key_tick", int'(tick), 3);
        cyc(8'h00, 12);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
